// File: rtl/axi_sram_rd_slave.sv
`timescale 1ns/1ps
// AXI4 read-only slave in front of a 64-bit synchronous SRAM. It takes one AR at a time
// and returns FIXED/INCR bursts at one beat per cycle. A backdoor port loads the array.
module axi_sram_rd_slave #(
   parameter int unsigned DEPTH_LOG2 = 12,
   parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
   parameter int unsigned ID_W       = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  arvalid,
   output logic                  arready,
   input  logic [ID_W-1:0]       arid,
   input  logic [63:0]           araddr,
   input  logic [7:0]            arlen,
   input  logic [2:0]            arsize,
   input  logic [1:0]            arburst,
   output logic                  rvalid,
   input  logic                  rready,
   output logic [ID_W-1:0]       rid,
   output logic [63:0]           rdata,
   output logic [1:0]            rresp,
   output logic                  rlast,
   input  logic                  load_en,
   input  logic [DEPTH_LOG2-1:0] load_addr,
   input  logic [63:0]           load_data
);
   localparam int unsigned DEPTH       = 2 ** DEPTH_LOG2;
   localparam int unsigned DATA_W      = 64;
   localparam logic [63:0] SPAN        = 64'(DEPTH) << 3;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [1:0]  RESP_DECERR = 2'b11;
   localparam logic [1:0]  BURST_INCR  = 2'b01;
   localparam logic [7:0]  MAX_LEN     = 8'd15;
   localparam logic [2:0]  SIZE_8B     = 3'b011;

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_ar_hs;
   logic                  w_issue;
   logic                  w_last_hs;
   logic                  w_r_hs;
   logic [63:0]           w_off;
   logic [63:0]           w_end_off;
   logic [DEPTH_LOG2-1:0] w_ar_idx;
   logic [1:0]            w_ar_resp;
   logic                  w_ar_incr;

   logic [DATA_W-1:0]     r_mem [DEPTH];
   logic                  r_arready;
   logic                  r_rvalid;
   logic                  r_rlast;
   logic [ID_W-1:0]       r_rid;
   logic [DATA_W-1:0]     r_rdata;
   logic [1:0]            r_rresp;
   logic [DEPTH_LOG2-1:0] r_idx;
   logic [7:0]            r_left;
   logic                  r_incr;

   // AR decode. An address below BASE_ADDR wraps to a huge offset, so one unsigned compare covers both ends.
   always_comb begin
      w_ar_incr = (arburst == BURST_INCR);
      w_off     = araddr - BASE_ADDR;
      w_end_off = w_ar_incr ? (w_off + (64'(arlen) << 3)) : w_off;
      w_ar_idx  = w_off[DEPTH_LOG2+2:3];
      if ((w_off >= SPAN) || (w_end_off >= SPAN))
         w_ar_resp = RESP_DECERR;
      else if (arburst[1] || (arlen > MAX_LEN) || (arsize != SIZE_8B))
         w_ar_resp = RESP_SLVERR;
      else
         w_ar_resp = RESP_OKAY;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state and per-cycle strobes
   always_comb begin
      w_state_nxt = r_state;
      w_ar_hs     = 1'b0;
      w_issue     = 1'b0;
      w_r_hs      = r_rvalid && rready;
      w_last_hs   = w_r_hs && r_rlast;
      case (r_state)
         S_IDLE: begin
            w_ar_hs = arvalid && r_arready;
            if (w_ar_hs) w_state_nxt = S_BURST;
         end
         S_BURST: begin
            w_issue = (r_left != 8'd0) && (!r_rvalid || rready);
            if (w_last_hs) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Backdoor write port; the read port sees the pre-write contents on a same-cycle collision
   always_ff @(posedge clk) begin
      if (load_en) r_mem[load_addr] <= load_data;
   end

   // R-channel datapath: the first beat is read in the AR handshake cycle, later beats on issue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_arready <= 1'b1;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rid     <= '0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
         r_idx     <= '0;
         r_left    <= '0;
         r_incr    <= 1'b0;
      end else begin
         r_arready <= (w_state_nxt == S_IDLE);
         if (w_ar_hs) begin
            r_rid    <= arid;
            r_rresp  <= w_ar_resp;
            r_incr   <= w_ar_incr;
            r_idx    <= w_ar_idx + DEPTH_LOG2'(w_ar_incr);
            r_left   <= arlen;
            r_rvalid <= 1'b1;
            r_rlast  <= (arlen == 8'd0);
            r_rdata  <= (w_ar_resp == RESP_OKAY) ? r_mem[w_ar_idx] : '0;
         end else if (w_issue) begin
            r_left   <= r_left - 8'd1;
            r_rvalid <= 1'b1;
            r_rlast  <= (r_left == 8'd1);
            r_rdata  <= (r_rresp == RESP_OKAY) ? r_mem[r_idx] : '0;
            if (r_incr) r_idx <= r_idx + DEPTH_LOG2'(1);
         end else if (w_r_hs) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
         end
      end
   end

   assign arready = r_arready;
   assign rvalid  = r_rvalid;
   assign rlast   = r_rlast;
   assign rid     = r_rid;
   assign rdata   = r_rdata;
   assign rresp   = r_rresp;

endmodule

// File: tb/tb_axi_sram_rd_slave.sv
`timescale 1ns/1ps
// Bench for axi_sram_rd_slave: table vectors, hand-built corner sequences and random bursts,
// all checked against a memory/response model kept in the bench.
module tb_axi_sram_rd_slave;
   localparam int          DEPTH = 4096;
   localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
   localparam logic [63:0] D1    = 64'h1111_1111_1111_1111;
   localparam logic [63:0] D2    = 64'h2222_2222_2222_2222;
   localparam logic [63:0] D3    = 64'h3333_3333_3333_3333;
   localparam logic [63:0] D4    = 64'h4444_4444_4444_4444;
   localparam logic [63:0] DTOP  = 64'hDEAD_BEEF_0BAD_F00D;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        arvalid;
   logic        arready;
   logic [3:0]  arid;
   logic [63:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid;
   logic        rready;
   logic [3:0]  rid;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        load_en;
   logic [11:0] load_addr;
   logic [63:0] load_data;

   int n_tests = 0;
   int n_fail  = 0;

   logic [63:0] mem_m [DEPTH];

   typedef struct {
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [3:0]  id;
      int          rr;
      logic [1:0]  exp_resp;
      logic [63:0] exp_d0;
   } vec_t;

   vec_t vecs [10];

   axi_sram_rd_slave dut (
      .clk(clk), .rst_n(rst_n),
      .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
      .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
      .rresp(rresp), .rlast(rlast),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish (n_fail=%0d)", n_fail);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Response class from the address-range and legality rules
   function automatic logic [1:0] model_resp(logic [63:0] a, logic [7:0] len, logic [2:0] sz,
                                              logic [1:0] b);
      logic [63:0] hi, e;
      hi = BASE + 64'(DEPTH) * 64'd8;
      e  = (b == 2'b01) ? a + 64'(len) * 64'd8 : a;
      if (a < BASE || a >= hi || e < BASE || e >= hi) return 2'b11;
      if (b >= 2'd2 || len > 8'd15 || sz != 3'd3) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [63:0] model_data(logic [63:0] a, logic [1:0] b, logic [1:0] resp, int i);
      int idx;
      if (resp != 2'b00) return 64'd0;
      idx = int'((a - BASE) / 64'd8) + ((b == 2'b01) ? i : 0);
      return mem_m[idx];
   endfunction

   function automatic logic rr_pick(int mode, int cyc);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (cyc % 3) == 0;
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic load_word(input int a, input logic [63:0] d);
      load_en   = 1'b1;
      load_addr = 12'(a);
      load_data = d;
      @(posedge clk); #1;
      load_en   = 1'b0;
      mem_m[a]  = d;
   endtask

   // One full AR + R transaction; optional backdoor load in the AR handshake cycle
   task automatic run_txn(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input int rr_mode,
                          input logic use_tab, input logic [1:0] tab_resp, input logic [63:0] tab_d0,
                          input logic ld, input logic [11:0] ld_a, input logic [63:0] ld_d,
                          input string tag);
      logic [63:0] exp_d [$];
      logic [1:0]  eresp;
      int          nb, k, cyc;
      eresp = use_tab ? tab_resp : model_resp(addr, len, size, burst);
      nb    = int'(len) + 1;
      for (int i = 0; i < nb; i++) exp_d.push_back(model_data(addr, burst, eresp, i));
      if (use_tab) exp_d[0] = tab_d0;
      for (int w = 0; w < 50 && !arready; w++) begin
         @(posedge clk); #1;
      end
      chk({tag, " arready idle"}, 64'(arready), 64'd1);
      arvalid = 1'b1; araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id;
      load_en = ld; load_addr = ld_a; load_data = ld_d;
      @(posedge clk); #1;
      arvalid = 1'b0; load_en = 1'b0;
      araddr  = {$urandom, $urandom}; arlen = 8'($urandom); arid = 4'($urandom);
      arburst = 2'($urandom); arsize = 3'($urandom);
      if (ld) mem_m[ld_a] = ld_d;
      chk({tag, " arready busy"}, 64'(arready), 64'd0);
      k = 0; cyc = 0;
      while (k < nb && cyc < 2000) begin
         chk($sformatf("%s b%0d rvalid", tag, k), 64'(rvalid), 64'd1);
         chk($sformatf("%s b%0d rdata", tag, k), rdata, exp_d[k]);
         chk($sformatf("%s b%0d rresp", tag, k), 64'(rresp), 64'(eresp));
         chk($sformatf("%s b%0d rlast", tag, k), 64'(rlast), 64'(k == nb - 1));
         chk($sformatf("%s b%0d rid", tag, k), 64'(rid), 64'(id));
         rready = rr_pick(rr_mode, cyc);
         if (rready) k++;
         @(posedge clk); #1;
         cyc++;
      end
      rready = 1'b0;
      chk({tag, " beats done"}, 64'(k), 64'(nb));
      chk({tag, " rvalid after"}, 64'(rvalid), 64'd0);
      chk({tag, " arready after"}, 64'(arready), 64'd1);
   endtask

   initial begin
      logic [63:0] ra;
      logic [7:0]  rl;
      logic [2:0]  rs;
      logic [1:0]  rb;
      rst_n = 1'b0; arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = 3'd3;
      arburst = 2'b01; rready = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset arready", 64'(arready), 64'd1);
      chk("reset rvalid", 64'(rvalid), 64'd0);
      chk("reset rlast", 64'(rlast), 64'd0);
      chk("reset rid", 64'(rid), 64'd0);
      chk("reset rdata", rdata, 64'd0);
      chk("reset rresp", 64'(rresp), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      for (int a = 0; a < DEPTH; a++) load_word(a, {$urandom, $urandom});
      load_word(0, D1); load_word(1, D2); load_word(2, D3); load_word(3, D4);
      load_word(DEPTH - 1, DTOP);

      vecs[0] = '{64'h8000_0000, 8'd3,  3'd3, 2'b01, 4'd5, 0, 2'b00, D1};
      vecs[1] = '{64'h8000_0000, 8'd3,  3'd3, 2'b01, 4'd5, 1, 2'b00, D1};
      vecs[2] = '{64'h8000_0008, 8'd2,  3'd3, 2'b00, 4'd2, 0, 2'b00, D2};
      vecs[3] = '{64'h7FFF_FFF8, 8'd0,  3'd3, 2'b01, 4'd3, 0, 2'b11, 64'd0};
      vecs[4] = '{64'h8000_7FF8, 8'd1,  3'd3, 2'b01, 4'd4, 2, 2'b11, 64'd0};
      vecs[5] = '{64'h8000_0000, 8'd3,  3'd3, 2'b10, 4'd6, 0, 2'b10, 64'd0};
      vecs[6] = '{64'h8000_0010, 8'd0,  3'd2, 2'b01, 4'd7, 0, 2'b10, 64'd0};
      vecs[7] = '{64'h8000_0018, 8'd16, 3'd3, 2'b01, 4'd8, 0, 2'b10, 64'd0};
      vecs[8] = '{64'h8000_7FF8, 8'd5,  3'd3, 2'b00, 4'd9, 1, 2'b00, DTOP};
      vecs[9] = '{64'h8000_0005, 8'd0,  3'd3, 2'b01, 4'd1, 0, 2'b00, D1};
      for (int v = 0; v < 10; v++)
         run_txn(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, vecs[v].id, vecs[v].rr,
                 1'b1, vecs[v].exp_resp, vecs[v].exp_d0, 1'b0, 12'd0, 64'd0,
                 $sformatf("vec%0d", v));

      // Backdoor write colliding with the first read of the same word
      run_txn(64'h8000_0040, 8'd0, 3'd3, 2'b01, 4'hA, 0, 1'b0, 2'b00, 64'd0,
              1'b1, 12'd8, 64'hCAFE_F00D_1234_5678, "collide_old");
      run_txn(64'h8000_0040, 8'd0, 3'd3, 2'b01, 4'hB, 0, 1'b1, 2'b00, 64'hCAFE_F00D_1234_5678,
              1'b0, 12'd0, 64'd0, "collide_new");

      // Reset during beat 2 of a 4-beat burst
      arvalid = 1'b1; araddr = BASE; arlen = 8'd3; arsize = 3'd3; arburst = 2'b01; arid = 4'd9;
      @(posedge clk); #1;
      arvalid = 1'b0; rready = 1'b1;
      chk("rst_seq beat1", rdata, D1);
      @(posedge clk); #1;
      chk("rst_seq beat2", rdata, D2);
      rst_n = 1'b0;
      #1;
      chk("rst_seq rvalid", 64'(rvalid), 64'd0);
      chk("rst_seq arready", 64'(arready), 64'd1);
      chk("rst_seq rlast", 64'(rlast), 64'd0);
      chk("rst_seq rid", 64'(rid), 64'd0);
      rready = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      run_txn(BASE, 8'd0, 3'd3, 2'b01, 4'd2, 0, 1'b1, 2'b00, D1, 1'b0, 12'd0, 64'd0, "post_rst");

      // Randomized bursts against the model, with occasional backdoor reloads in between
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 2) == 0)
            for (int j = 0; j < int'($urandom_range(1, 3)); j++)
               load_word(int'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom});
         case ($urandom_range(0, 4))
            0: ra = BASE + 64'd8 * 64'($urandom_range(0, DEPTH - 1));
            1: ra = BASE + 64'($urandom_range(0, DEPTH * 8 - 1));
            2: ra = BASE + 64'(DEPTH * 8) - 64'd8 * 64'($urandom_range(1, 4));
            3: ra = BASE - 64'd8 * 64'($urandom_range(1, 4));
            default: ra = 64'h0000_0001_8000_0000 + 64'($urandom_range(0, 255));
         endcase
         rl = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 20)) : 8'($urandom_range(0, 15));
         rs = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
         rb = 2'($urandom_range(0, 3));
         run_txn(ra, rl, rs, rb, 4'($urandom), int'($urandom_range(0, 2)),
                 1'b0, 2'b00, 64'd0, 1'b0, 12'd0, 64'd0, $sformatf("rnd%0d", t));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
